// File: rtl/l1i_cache.sv
`default_nettype none
// ============================================================================
// Module      : l1i_cache
// Description : Direct-mapped read-only L1 instruction cache. Hits are served
//               combinationally; misses refill a whole line word-by-word.
// Revision    : 1.0 - initial release
// ============================================================================
module l1i_cache #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    output logic [31:0] cpu_data,
    output logic        cpu_stall,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_data,
    input  logic        mem_stall
);

    localparam int c_ob = $clog2(WORDS_PER_LINE);
    localparam int c_ib = $clog2(LINES);
    localparam int c_tw = 30 - c_ob - c_ib;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [c_tw-1:0]   r_tag_arr  [LINES];
    logic [31:0]       r_data_arr [LINES*WORDS_PER_LINE];
    logic [c_tw-1:0]   r_fill_tag;
    logic [c_ib-1:0]   r_fill_idx;
    logic [c_ob-1:0]   r_cnt;

    logic [c_ob-1:0]   w_off;
    logic [c_ib-1:0]   w_idx;
    logic [c_tw-1:0]   w_tag;
    logic              w_hit;
    logic              w_idle;
    logic              w_miss;
    logic              w_last;
    logic              w_unused_addr;

    assign w_off         = cpu_address[c_ob+1:2];
    assign w_idx         = cpu_address[c_ob+c_ib+1:c_ob+2];
    assign w_tag         = cpu_address[31:c_ob+c_ib+2];
    assign w_unused_addr = &{1'b0, cpu_address[1:0]};

    assign w_idle = (r_state == S_IDLE);
    assign w_hit  = cpu_read & r_valid[w_idx] & (r_tag_arr[w_idx] == w_tag);
    assign w_miss = w_idle & cpu_read & ~w_hit;
    // WORDS_PER_LINE is a power of two, so the last word has an all-ones offset
    assign w_last = &r_cnt;

    // Outputs are forced low while reset is held, independent of the clock
    assign cpu_stall   = reset_n & (~w_idle | w_miss);
    assign cpu_data    = (reset_n & w_idle & w_hit) ? r_data_arr[{w_idx, w_off}] : 32'd0;
    assign mem_read    = reset_n & (r_state == S_REQ);
    assign mem_address = mem_read ? {2'b00, r_fill_tag, r_fill_idx, r_cnt} : 32'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_cnt      <= '0;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_fill_tag <= w_tag;
                        r_fill_idx <= w_idx;
                        r_cnt      <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!mem_stall) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_last) begin
                        r_valid[r_fill_idx] <= 1'b1;
                        r_state             <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked solely by r_valid
    always_ff @(posedge clock) begin
        if (r_state == S_WAIT) begin
            r_data_arr[{r_fill_idx, r_cnt}] <= mem_data;
            if (w_last) begin
                r_tag_arr[r_fill_idx] <= r_fill_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1i_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1i_cache
// Description : Directed self-checking bench for l1i_cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1i_cache;

    logic        clock;
    logic        reset_n;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic [31:0] cpu_data;
    logic        cpu_stall;
    logic        flush;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        mem_stall;

    int          checks;
    int          errors;
    int          stalls;
    logic [31:0] req_q[$];

    l1i_cache #(
        .LINES         (8),
        .WORDS_PER_LINE(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_address(cpu_address),
        .cpu_read   (cpu_read),
        .cpu_data   (cpu_data),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_address(mem_address),
        .mem_read   (mem_read),
        .mem_data   (mem_data),
        .mem_stall  (mem_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle synchronous ROM: word at address A holds 0x100 + A
    always @(posedge clock) begin
        if (mem_read && !mem_stall) begin
            mem_data <= 32'h100 + mem_address;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] req_at(input int i);
        return (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF;
    endfunction

    // Present a fetch and run until cpu_stall drops; mem_stall is held for
    // the first hold_cycles REQ cycles observed.
    task automatic fetch(input logic [31:0] a, input int hold_cycles, output int n_stall);
        int left;
        left    = hold_cycles;
        n_stall = 0;
        req_q.delete();
        @(posedge clock);
        #1;
        cpu_address = a;
        cpu_read    = 1'b1;
        @(negedge clock);
        while (cpu_stall && n_stall < 60) begin
            n_stall++;
            if (mem_read) req_q.push_back(mem_address);
            mem_stall = mem_read && (left > 0);
            if (mem_stall) left--;
            @(negedge clock);
        end
        mem_stall = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clock);
        #1;
        cpu_read = 1'b0;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        cpu_address = 32'd0;
        cpu_read    = 1'b0;
        flush       = 1'b0;
        mem_data    = 32'd0;
        mem_stall   = 1'b0;

        #3;
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_cpu_data", cpu_data, 32'd0);
        #20;
        reset_n = 1'b1;

        // Cold miss on line 1
        fetch(32'h10, 0, stalls);
        check("miss_stalls", stalls, 9);
        check("miss_nreq", req_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("miss_addr%0d", i), req_at(i), 32'd4 + i);
        check("miss_data", cpu_data, 32'h104);
        check("miss_mem_read", {31'd0, mem_read}, 32'd0);

        // Hits on the remaining words of the line
        fetch(32'h14, 0, stalls);
        check("hit14_stalls", stalls, 0);
        check("hit14_data", cpu_data, 32'h105);
        fetch(32'h18, 0, stalls);
        check("hit18_data", cpu_data, 32'h106);
        fetch(32'h1C, 0, stalls);
        check("hit1c_data", cpu_data, 32'h107);
        check("hit1c_nreq", req_q.size(), 0);

        // Memory stall during the first REQ
        do_flush();
        fetch(32'h10, 3, stalls);
        check("mstall_stalls", stalls, 12);
        check("mstall_nreq", req_q.size(), 7);
        for (int i = 0; i < 4; i++) check($sformatf("mstall_hold%0d", i), req_at(i), 32'd4);
        check("mstall_last", req_at(6), 32'd7);
        check("mstall_data", cpu_data, 32'h104);

        // Conflict miss: 0x90 shares index 1 with 0x10
        fetch(32'h90, 0, stalls);
        check("conf_stalls", stalls, 9);
        check("conf_addr0", req_at(0), 32'h24);
        check("conf_addr3", req_at(3), 32'h27);
        check("conf_data", cpu_data, 32'h124);
        fetch(32'h10, 0, stalls);
        check("conf_refetch_stalls", stalls, 9);
        check("conf_refetch_data", cpu_data, 32'h104);

        // Flush during WAIT of the second word
        do_flush();
        @(posedge clock);
        #1;
        cpu_address = 32'h10;
        cpu_read    = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("fl_in_wait_stall", {31'd0, cpu_stall}, 32'd1);
        check("fl_in_wait_mem_read", {31'd0, mem_read}, 32'd0);
        cpu_read = 1'b0;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check("fl_idle_stall", {31'd0, cpu_stall}, 32'd0);
        check("fl_idle_mem_read", {31'd0, mem_read}, 32'd0);
        fetch(32'h10, 0, stalls);
        check("fl_refill_stalls", stalls, 9);
        check("fl_refill_nreq", req_q.size(), 4);
        check("fl_refill_data", cpu_data, 32'h104);

        // Asynchronous reset in the middle of a refill
        do_flush();
        @(posedge clock);
        #1;
        cpu_address = 32'h10;
        cpu_read    = 1'b1;
        @(posedge clock);
        #1;
        check("ar_pre_mem_read", {31'd0, mem_read}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_stall", {31'd0, cpu_stall}, 32'd0);
        check("ar_mem_read", {31'd0, mem_read}, 32'd0);
        check("ar_mem_addr", mem_address, 32'd0);
        check("ar_cpu_data", cpu_data, 32'd0);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        cpu_read = 1'b0;
        fetch(32'h10, 0, stalls);
        check("ar_refetch_stalls", stalls, 9);
        check("ar_refetch_data", cpu_data, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
